// File: rtl/dsp_seq_pkg.sv
// Shared types and register map for the DSP routing sequencer.
package dsp_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_WRITE,
        S_WACK,
        S_DWELL,
        S_DONE
    } state_t;

    // Module slot 0xF is the DSP's NONE code, so it is free for our own registers
    localparam logic [3:0]  SLOT_LOCAL = 4'hF;

    localparam logic [15:0] OFF_CTRL   = 16'h0000;
    localparam logic [15:0] OFF_STATUS = 16'h0004;
    localparam logic [15:0] OFF_COUNT  = 16'h0008;
    localparam logic [7:0]  OFF_TABLE  = 8'h01;

    localparam int CTRL_ARM    = 0;
    localparam int CTRL_LOOP   = 1;
    localparam int CTRL_SWTRIG = 2;
    localparam int CTRL_ABORT  = 3;

    localparam int ENT_MOD_LSB  = 0;
    localparam int ENT_REG_BIT  = 8;
    localparam int ENT_DATA_LSB = 16;

    localparam logic [3:0] SEL_INPUT  = 4'h0;
    localparam logic [3:0] SEL_OUTPUT = 4'h4;

endpackage

// File: rtl/dsp_seq_table.sv
// DEPTH x 2-word routing table: one PS read/write port, one sequencer read port.
module dsp_seq_table #(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] ps_idx,
    input  logic                     ps_word,
    input  logic [31:0]              wr_data,
    output logic [31:0]              ps_rdata,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [31:0]              rd_w0,
    output logic [31:0]              rd_w1
);

    logic [DEPTH-1:0][1:0][31:0] mem;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            mem <= '0;
        else if (wr_en)
            mem[ps_idx][ps_word] <= wr_data;
    end

    assign ps_rdata = mem[ps_idx][ps_word];
    assign rd_w0    = mem[rd_idx][0];
    assign rd_w1    = mem[rd_idx][1];

endmodule

// File: rtl/dsp_route_sequencer.sv
// Table-driven routing sequencer and PS-priority bus arbiter in front of red_pitaya_dsp.
module dsp_route_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int LOG_MODULES = 4,
    parameter int DWELL_BITS  = 24,
    parameter int TIMEOUT     = 16
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic [31:0]              ps_addr,
    input  logic [31:0]              ps_wdata,
    input  logic [3:0]               ps_sel,
    input  logic                     ps_wen,
    input  logic                     ps_ren,
    output logic [31:0]              ps_rdata,
    output logic                     ps_ack,
    output logic                     ps_err,
    output logic [31:0]              dsp_addr,
    output logic [31:0]              dsp_wdata,
    output logic [3:0]               dsp_sel,
    output logic                     dsp_wen,
    output logic                     dsp_ren,
    input  logic [31:0]              dsp_rdata,
    input  logic                     dsp_ack,
    input  logic                     dsp_err,
    input  logic                     trig_i,
    output logic                     busy_o,
    output logic [$clog2(DEPTH)-1:0] step_o
);

    localparam int SW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t                state, state_nx;
    logic [SW-1:0]         step, step_nx, last_step;
    logic [DWELL_BITS-1:0] dwell_cnt, dwell_cnt_nx, dwell_load, ent_dwell;
    logic [TW-1:0]         to_cnt, to_cnt_nx;
    logic                  err, err_nx, abort_pend, abort_pend_nx;
    logic                  arm, loop_en, trig_q, ps_pend, local_ack;
    logic [7:0]            count;
    logic [31:0]           local_rdata, local_rd, tbl_rdata, seq_w0, seq_w1, seq_addr;

    logic is_local, ps_strobe, fwd, ps_owner, lwr, ctrl_wr, tbl_hit;
    logic arm_wr, abort_wr, trig, seq_issue, seq_ack, seq_err, timeout, ent_reg;
    logic [LOG_MODULES-1:0] ent_mod;
    logic [7:0]             ent_data;
    logic [15:0]            off;
    logic                   unused_bits;

    assign off       = ps_addr[15:0];
    assign is_local  = (ps_addr[19:16] == SLOT_LOCAL);
    assign ps_strobe = ps_wen | ps_ren;
    assign fwd       = ps_strobe & ~is_local;
    assign ps_owner  = fwd | ps_pend;
    assign lwr       = ps_wen & is_local;
    assign ctrl_wr   = lwr && (off == OFF_CTRL);
    assign arm_wr    = ctrl_wr & ps_wdata[CTRL_ARM];
    assign abort_wr  = ctrl_wr & ps_wdata[CTRL_ABORT];
    assign trig      = (trig_i & ~trig_q) | (ctrl_wr & ps_wdata[CTRL_SWTRIG]);
    assign tbl_hit   = (off[15:8] == OFF_TABLE) && ({27'h0, off[7:3]} < 32'(DEPTH));

    dsp_seq_table #(.DEPTH(DEPTH)) u_table (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .wr_en    (lwr & tbl_hit),
        .ps_idx   (off[3 +: SW]),
        .ps_word  (off[2]),
        .wr_data  (ps_wdata),
        .ps_rdata (tbl_rdata),
        .rd_idx   (step),
        .rd_w0    (seq_w0),
        .rd_w1    (seq_w1)
    );

    assign ent_mod     = seq_w0[ENT_MOD_LSB +: LOG_MODULES];
    assign ent_reg     = seq_w0[ENT_REG_BIT];
    assign ent_data    = seq_w0[ENT_DATA_LSB +: 8];
    assign ent_dwell   = seq_w1[DWELL_BITS-1:0];
    assign dwell_load  = (ent_dwell == '0) ? '0 : ent_dwell - DWELL_BITS'(1);
    assign seq_addr    = {12'h0, 4'(ent_mod), 12'h0, ent_reg ? SEL_OUTPUT : SEL_INPUT};
    assign last_step   = (count == 8'd0)       ? '0 :
                         (count > 8'(DEPTH))   ? SW'(DEPTH - 1) : SW'(count - 8'd1);
    assign unused_bits = ^{seq_w0, seq_w1};

    // The sequencer only drives the bus when the PS is completely quiet
    assign seq_issue = (state == S_WRITE) && !ps_strobe && !ps_pend;
    assign seq_ack   = dsp_ack & ~ps_owner;
    assign seq_err   = dsp_err & ~ps_owner;
    assign timeout   = (to_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        state_nx      = state;
        step_nx       = step;
        dwell_cnt_nx  = dwell_cnt;
        to_cnt_nx     = to_cnt;
        err_nx        = err;
        abort_pend_nx = abort_pend;
        case (state)
            S_IDLE:  if (arm_wr && !abort_wr) begin state_nx = S_ARMED; err_nx = 1'b0; end
            S_ARMED: if (abort_wr) state_nx = S_IDLE;
                     else if (trig) begin state_nx = S_WRITE; step_nx = '0; end
            S_WRITE: begin
                if (abort_wr) state_nx = S_IDLE;
                else if (seq_issue) begin
                    to_cnt_nx = '0;
                    // A same-cycle ack skips WACK entirely
                    if (seq_ack)      begin state_nx = S_DWELL; dwell_cnt_nx = dwell_load; end
                    else if (seq_err) begin state_nx = S_DONE;  err_nx = 1'b1; end
                    else              state_nx = S_WACK;
                end
            end
            S_WACK: begin
                abort_pend_nx = abort_pend | abort_wr;
                to_cnt_nx     = to_cnt + TW'(1);
                if (seq_ack || seq_err || timeout) begin
                    abort_pend_nx = 1'b0;
                    if (abort_pend || abort_wr) state_nx = S_IDLE;
                    else if (seq_ack) begin state_nx = S_DWELL; dwell_cnt_nx = dwell_load; end
                    else begin state_nx = S_DONE; err_nx = 1'b1; end
                end
            end
            S_DWELL: begin
                if (abort_wr) state_nx = S_IDLE;
                else if (dwell_cnt != '0) dwell_cnt_nx = dwell_cnt - DWELL_BITS'(1);
                else if (step != last_step) begin state_nx = S_WRITE; step_nx = step + SW'(1); end
                else if (loop_en) begin state_nx = S_WRITE; step_nx = '0; end
                else state_nx = S_DONE;
            end
            S_DONE:  if (abort_wr) state_nx = S_IDLE;
                     else if (arm_wr) begin state_nx = S_ARMED; err_nx = 1'b0; end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= S_IDLE;
            step       <= '0;
            dwell_cnt  <= '0;
            to_cnt     <= '0;
            err        <= 1'b0;
            abort_pend <= 1'b0;
        end else begin
            state      <= state_nx;
            step       <= step_nx;
            dwell_cnt  <= dwell_cnt_nx;
            to_cnt     <= to_cnt_nx;
            err        <= err_nx;
            abort_pend <= abort_pend_nx;
        end
    end

    always_comb begin
        local_rd = '0;
        if (tbl_hit) local_rd = tbl_rdata;
        else case (off)
            OFF_CTRL:   local_rd = {30'h0, loop_en, arm};
            OFF_STATUS: local_rd = {20'h0, 4'(step), 5'h0, err, state == S_DONE, busy_o};
            OFF_COUNT:  local_rd = {24'h0, count};
            default:    local_rd = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            arm         <= 1'b0;
            loop_en     <= 1'b0;
            count       <= '0;
            trig_q      <= 1'b0;
            ps_pend     <= 1'b0;
            local_ack   <= 1'b0;
            local_rdata <= '0;
        end else begin
            trig_q    <= trig_i;
            local_ack <= ps_strobe & is_local;
            if (ps_strobe & is_local) local_rdata <= local_rd;
            if (ctrl_wr) begin
                arm     <= ps_wdata[CTRL_ARM];
                loop_en <= ps_wdata[CTRL_LOOP];
            end
            if (lwr && off == OFF_COUNT) count <= ps_wdata[7:0];
            if (dsp_ack | dsp_err) ps_pend <= 1'b0;
            else if (fwd)          ps_pend <= 1'b1;
        end
    end

    assign busy_o    = (state != S_IDLE) && (state != S_DONE);
    assign step_o    = step;
    assign dsp_wen   = seq_issue | (ps_wen & ~is_local);
    assign dsp_ren   = ps_ren & ~is_local;
    assign dsp_addr  = seq_issue ? seq_addr         : (ps_owner ? ps_addr  : '0);
    assign dsp_wdata = seq_issue ? {24'h0, ent_data} : (ps_owner ? ps_wdata : '0);
    assign dsp_sel   = seq_issue ? 4'hF             : (ps_owner ? ps_sel   : '0);
    assign ps_ack    = local_ack | (ps_owner & dsp_ack);
    assign ps_err    = ps_owner & dsp_err;
    assign ps_rdata  = ps_owner ? dsp_rdata : (local_ack ? local_rdata : '0);

endmodule

// File: doc/dsp_route_sequencer.md
# dsp_route_sequencer

Table-driven routing sequencer and bus arbiter placed between the PS system bus and `red_pitaya_dsp`. On a trigger it replays a programmed list of routing writes, one per entry, each followed by a programmable dwell time. The writes target the DSP's per-module `input_select` (offset 0x0) and `output_select` (offset 0x4) registers. PS traffic always has priority and passes through unchanged. The sequencer's own registers occupy module slot 0xF, which is the DSP's `NONE` code and so never forwarded.

## Interface
- DEPTH, 8: table entries, power of two, 2..16
- LOG_MODULES, 4: module-index width, matching the DSP
- DWELL_BITS, 24: dwell counter width
- TIMEOUT, 16: cycles to wait for `dsp_ack` before error

- clk_i  in  1  processing clock
- rstn_i  in  1  reset; one clock; reset is asynchronous and active-low
- ps_addr/ps_wdata  in  32/32  PS bus address/data
- ps_sel  in  4  byte select
- ps_wen/ps_ren  in  1/1  single-cycle PS strobes
- ps_rdata  out  32  read data
- ps_ack/ps_err  out  1/1  PS acknowledge/error
- dsp_addr/dsp_wdata  out  32/32  to DSP `sys_addr`/`sys_wdata`
- dsp_sel  out  4  to DSP
- dsp_wen/dsp_ren  out  1/1  to DSP
- dsp_rdata  in  32  from DSP
- dsp_ack/dsp_err  in  1/1  from DSP
- trig_i  in  1  external trigger; rising edge counts
- busy_o  out  1  FSM not IDLE/DONE
- step_o  out  log2(DEPTH)  current entry index

## Operation
- Decode: `ps_addr[19:16]==4'hF` is local. Local accesses are not forwarded; they get `ps_ack` one cycle after the strobe and `ps_err=0`.
- All other PS accesses are forwarded combinationally to the `dsp_*` outputs. `ps_rdata/ps_ack/ps_err` mirror `dsp_*` only while the owner is PS.
- Local registers:
  - 0x0 CTRL: bit0 arm, bit1 loop, bit2 sw_trig (self-clearing), bit3 abort (self-clearing)
  - 0x4 STATUS (RO): bit0 busy, bit1 done, bit2 err, bits[11:8] step
  - 0x8 COUNT: 1..DEPTH; 0 is treated as 1
  - 0x100+8k ENTRY_k word0: [3:0] module, [8] reg (0=input_select, 1=output_select), [23:16] data
  - 0x104+8k ENTRY_k word1: dwell
- States and transitions:
  - IDLE → ARMED when arm is written 1.
  - ARMED → WRITE on a trigger (trig_i rising edge or sw_trig), with step=0.
  - WRITE: assert `dsp_wen` for exactly one cycle, only when the PS has no strobe this cycle and no forwarded PS access is outstanding. Otherwise stall in WRITE.
  - WRITE → WACK.
  - WACK → DWELL on `dsp_ack`. WACK → DONE with err=1 on `dsp_err` or after TIMEOUT cycles.
  - DWELL: count max(dwell,1) cycles, then advance step.
  - After the last entry (step==COUNT-1): go to WRITE with step=0 if loop=1, else DONE.
  - DONE → ARMED on arm written 1; this clears done and err.
- Sequencer write: `dsp_addr={12'h0, module, 12'h0, reg?4'h4:4'h0}`, `dsp_wdata={24'h0,data}`, `dsp_sel=4'hF`.
- Simultaneous events and boundaries:
  - abort overrides trigger and goes to IDLE from any state. In WACK, abort waits for ack or timeout first.
  - A trigger outside ARMED is ignored.
  - Table writes while busy are accepted; the new value is used the next time that entry is fetched.
  - An async reset mid-sequence forces IDLE and clears all outputs immediately.

## Timing
- Reset: all outputs 0, state IDLE, CTRL/COUNT 0, table contents 0.
- Trigger edge sampled at cycle n → `dsp_wen` at n+1 (absent PS activity).
- DSP ack at m → DWELL begins at m+1. The next `dsp_wen` occurs at m+1+max(dwell,1).
- PS passthrough adds zero cycles. A sequencer write is delayed by at most one PS transaction.

## Structure
- Package `dsp_seq_pkg` holds:
  - the state enum
  - local register offsets and the slot code 4'hF
  - ENTRY field positions and the input/output_select offsets
- Sub-module `dsp_seq_table`: DEPTH×2 register file with PS write port and sequencer read port.
- Top level holds the FSM, arbiter, and dwell/timeout counters.

## Test plan
- COUNT=2, entries {mod 0, in, 0x0A, dwell 5} and {mod 8, out, 0x1, dwell 3}, arm, trig_i edge → writes of 0xA to 0x00000 and 1 to 0x80004. The writes are 6 cycles apart; DONE follows.
- PS write strobe to 0x30000 in the same cycle the sequencer would write → PS forwarded first. Sequencer `dsp_wen` occurs the cycle after the PS ack, and the PS never sees the sequencer's ack.
- Hold `dsp_ack` low → err=1 and DONE after 16 cycles; `ps_ack` is unaffected.
- loop=1, COUNT=1, dwell=0 → a write every 2 cycles until abort; abort during DWELL → IDLE the next cycle.
- Trigger and abort in the same cycle while ARMED → IDLE with no DSP write. Assert rstn_i low mid-DWELL → outputs 0 without waiting for a clock edge.
